fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_next_pc_sel.sv | 24 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: reset vector, redirect
// source codes and FSM state encodings.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsource_e;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: decode redirect/stall inputs, decode-facing
// instruction outputs and the SRAM-like read-only instruction port.
interface fetch_unit_if;

  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] jrpc;
  logic        id_stall;

  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    input  pcsource, bpc, jpc, jrpc, id_stall,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output o_inst, o_pc, o_valid,
    output inst_req, inst_addr
  );

  modport slave (
    output pcsource, bpc, jpc, jrpc, id_stall,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  o_inst, o_pc, o_valid,
    input  inst_req, inst_addr
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational redirect-target selector: +4 / branch / jump-register / jump.
// Zero latency; no flow control of its own.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    case (pcsource)
      PC_BR:   next_pc = bpc;
      PC_JR:   next_pc = jrpc;
      PC_J:    next_pc = jpc;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher with one-slot branch delay handling.
// Three cycles minimum per instruction; holds its outputs while decode stalls.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redir_target_q, redir_target_d;
  logic         redir_pending_q, redir_pending_d;
  logic [31:0]  o_inst_q, o_inst_d;
  logic [31:0]  o_pc_q, o_pc_d;
  logic         o_valid_q, o_valid_d;

  logic         accept;
  logic [31:0]  seq_pc;
  logic [31:0]  sel_target;
  logic         req_active;

  assign accept = o_valid_q & ~bus.id_stall;
  assign seq_pc = pc_plus4(fetch_pc_q);

  next_pc_sel u_next_pc_sel (
    .pcsource (bus.pcsource),
    .pc_plus4 (seq_pc),
    .bpc      (bus.bpc),
    .jrpc     (bus.jrpc),
    .jpc      (bus.jpc),
    .next_pc  (sel_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_REQ;
      fetch_pc_q      <= RESET_VECTOR;
      redir_target_q  <= '0;
      redir_pending_q <= 1'b0;
      o_inst_q        <= '0;
      o_pc_q          <= '0;
      o_valid_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      redir_target_q  <= redir_target_d;
      redir_pending_q <= redir_pending_d;
      o_inst_q        <= o_inst_d;
      o_pc_q          <= o_pc_d;
      o_valid_q       <= o_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    redir_target_d  = redir_target_q;
    redir_pending_d = redir_pending_q;
    o_inst_d        = o_inst_q;
    o_pc_d          = o_pc_q;
    o_valid_d       = o_valid_q;

    case (state_q)
      ST_REQ: begin
        if (bus.inst_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // fetch_pc only moves on accept, so it is still the issued address here
        if (bus.inst_data_ok) begin
          o_inst_d  = bus.inst_rdata;
          o_pc_d    = fetch_pc_q;
          o_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          o_valid_d = 1'b0;
          state_d   = ST_REQ;
          // A redirect seen in the delay slot is dropped: the pending target wins
          if (redir_pending_q) begin
            fetch_pc_d      = redir_target_q;
            redir_pending_d = 1'b0;
          end else begin
            fetch_pc_d = seq_pc;
            if (bus.pcsource != PC_SEQ) begin
              redir_target_d  = sel_target;
              redir_pending_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Gated by reset so no request escapes while the block is held in reset
  assign req_active    = (state_q == ST_REQ) & reset;
  assign bus.inst_req  = req_active;
  assign bus.inst_addr = req_active ? fetch_pc_q : 32'd0;
  assign bus.o_inst    = o_inst_q;
  assign bus.o_pc      = o_pc_q;
  assign bus.o_valid   = o_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a behavioural PC model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pend;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'hBFC0_0000;
    m_tgt  = 32'h0;
    m_pend = 1'b0;
  endtask

  // Architectural rule: delay slot first, then the latched target; a second
  // redirect arriving in the delay slot is discarded.
  task automatic model_accept(input logic [1:0] ps, input logic [31:0] b,
                              input logic [31:0] jr, input logic [31:0] j);
    if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
      if (ps != 2'b00) begin
        m_tgt  = (ps == 2'b01) ? b : (ps == 2'b10) ? jr : j;
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic randomize_redirect();
    bus.pcsource = 2'($urandom_range(0, 3));
    bus.bpc      = $urandom;
    bus.jrpc     = $urandom;
    bus.jpc      = $urandom;
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at the negedge after accept.
  task automatic fetch_one(input int ad, input int dd, input int st,
                           input logic [1:0] ps, input logic [31:0] b,
                           input logic [31:0] jr, input logic [31:0] j,
                           input logic [31:0] rd);
    logic [31:0] ea;
    ea = m_pc;
    for (int i = 0; i < ad; i++) begin
      check("req_held", 32'(bus.inst_req), 32'd1);
      check("addr_held", bus.inst_addr, ea);
      check("no_valid_in_req", 32'(bus.o_valid), 32'd0);
      bus.inst_data_ok = (i == 0);
      bus.inst_rdata   = ~rd;
      @(negedge clk);
    end
    check("req", 32'(bus.inst_req), 32'd1);
    check("addr", bus.inst_addr, ea);
    check("no_valid_in_req", 32'(bus.o_valid), 32'd0);
    bus.inst_data_ok = 1'b0;
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    check("wait_req", 32'(bus.inst_req), 32'd0);
    check("wait_addr", bus.inst_addr, 32'd0);
    for (int i = 0; i < dd; i++) begin
      bus.inst_addr_ok = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wait_valid", 32'(bus.o_valid), 32'd0);
      check("wait_req", 32'(bus.inst_req), 32'd0);
    end
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = rd;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = $urandom;
    check("valid", 32'(bus.o_valid), 32'd1);
    check("o_pc", bus.o_pc, ea);
    check("o_inst", bus.o_inst, rd);
    for (int i = 0; i < st; i++) begin
      bus.id_stall = 1'b1;
      randomize_redirect();
      @(negedge clk);
      check("stall_valid", 32'(bus.o_valid), 32'd1);
      check("stall_pc", bus.o_pc, ea);
      check("stall_inst", bus.o_inst, rd);
      check("stall_req", 32'(bus.inst_req), 32'd0);
    end
    bus.id_stall = 1'b0;
    bus.pcsource = ps;
    bus.bpc      = b;
    bus.jrpc     = jr;
    bus.jpc      = j;
    @(negedge clk);
    randomize_redirect();
    check("post_accept_valid", 32'(bus.o_valid), 32'd0);
    check("post_accept_req", 32'(bus.inst_req), 32'd1);
    model_accept(ps, b, jr, j);
  endtask

  task automatic fetch_seq(input logic [31:0] rd);
    fetch_one(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, rd);
  endtask

  initial begin
    logic [1:0]  ps;
    logic [31:0] b, jr, j;

    reset            = 1'b0;
    bus.pcsource     = 2'b00;
    bus.bpc          = 32'h0;
    bus.jrpc         = 32'h0;
    bus.jpc          = 32'h0;
    bus.id_stall     = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("rst_req", 32'(bus.inst_req), 32'd0);
      check("rst_addr", bus.inst_addr, 32'd0);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_pc", bus.o_pc, 32'd0);
      check("rst_inst", bus.o_inst, 32'd0);
    end
    reset = 1'b1;
    #1;
    check("first_addr", bus.inst_addr, 32'hBFC0_0000);

    // Immediate acks, then a 5-cycle decode stall on the first instruction
    fetch_one(0, 0, 5, 2'b00, 32'h0, 32'h0, 32'h0, 32'h2401_0001);
    check("addr_after_stall", bus.inst_addr, 32'hBFC0_0004);
    fetch_seq($urandom);
    fetch_one(4, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    fetch_one(1, 2, 1, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    check("at_10", bus.inst_addr, 32'hBFC0_0010);

    // Branch at 0x...10: delay slot 0x...14, then the branch target
    fetch_one(0, 0, 0, PC_BR, 32'hBFC0_0100, 32'h0, 32'h0, $urandom);
    check("br_delay_slot", bus.inst_addr, 32'hBFC0_0014);
    fetch_seq($urandom);
    check("br_target", bus.inst_addr, 32'hBFC0_0100);
    fetch_one(0, 0, 0, PC_J, 32'h0, 32'h0, 32'hBFC0_001C, $urandom);
    fetch_seq($urandom);
    fetch_seq($urandom);
    check("at_20", bus.inst_addr, 32'hBFC0_0020);

    // Jump-register with a jump sitting in its delay slot
    fetch_one(0, 1, 0, PC_JR, 32'h0, 32'h8000_1000, 32'h0, $urandom);
    check("jr_delay_slot", bus.inst_addr, 32'hBFC0_0024);
    fetch_one(0, 0, 2, PC_J, 32'h0, 32'h0, 32'h0, $urandom);
    check("jr_target", bus.inst_addr, 32'h8000_1000);

    // Wrap of the sequential PC past the top of the address space
    fetch_one(0, 0, 0, PC_J, 32'h0, 32'h0, 32'hFFFF_FFF8, $urandom);
    fetch_seq($urandom);
    fetch_seq($urandom);
    check("at_fffffffc", bus.inst_addr, 32'hFFFF_FFFC);
    fetch_seq($urandom);
    check("wrap", bus.inst_addr, 32'h0000_0000);

    repeat (40) begin
      ps = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b  = $urandom & 32'hFFFF_FFFC;
      jr = $urandom & 32'hFFFF_FFFC;
      j  = $urandom & 32'hFFFF_FFFC;
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ps, b, jr, j, $urandom);
    end

    // Reset while holding a valid instruction
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1234_5678;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    bus.id_stall     = 1'b1;
    check("hold_before_rst", 32'(bus.o_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_hold_valid", 32'(bus.o_valid), 32'd0);
    check("rst_hold_pc", bus.o_pc, 32'd0);
    check("rst_hold_inst", bus.o_inst, 32'd0);
    check("rst_hold_req", 32'(bus.inst_req), 32'd0);
    @(negedge clk);
    bus.id_stall = 1'b0;
    reset        = 1'b1;
    model_reset();
    #1;
    check("rel_addr", bus.inst_addr, 32'hBFC0_0000);

    // Reset while waiting for data; the late data beat must be dropped
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    check("in_wait_req", 32'(bus.inst_req), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_wait_valid", 32'(bus.o_valid), 32'd0);
    check("rst_wait_req", 32'(bus.inst_req), 32'd0);
    @(negedge clk);
    reset            = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    check("late_data_valid", 32'(bus.o_valid), 32'd0);
    check("late_data_req", 32'(bus.inst_req), 32'd1);
    check("late_data_addr", bus.inst_addr, 32'hBFC0_0000);
    fetch_one(1, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h2401_0001);
    check("after_rst_seq", bus.inst_addr, 32'hBFC0_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
